// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: operation encodings,
// FSM state encodings and the default datapath width.
package div_iter_pkg;

    // Default operand/result width used by the divider core.
    localparam int DIV_XLEN = 32;

    // Operation encodings: bit 0 = unsigned, bit 1 = remainder.
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // One-hot FSM state encodings.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ITER = 4'b0010,
        ST_FIX  = 4'b0100,
        ST_DONE = 4'b1000
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// Combinational chain of UNROLL restoring-division steps. The dividend
// shift register supplies one bit per step from its MSB; the quotient
// bits are returned separately and merged into the shift register by
// the caller.
module div_step #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic [XLEN-1:0]   rem_in,
    input  logic [XLEN-1:0]   sh_in,
    input  logic [XLEN-1:0]   divisor,
    output logic [XLEN-1:0]   rem_out,
    output logic [XLEN-1:0]   sh_out,
    output logic [UNROLL-1:0] q_bits
);

    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] sh_s;

    // Chain of restoring steps; the trial value keeps the full XLEN+1 bits
    // so the shifted-in remainder is never truncated before comparison.
    always_comb begin
        rem_s   = rem_in;
        sh_s    = sh_in;
        trial_s = {(XLEN+1){1'b0}};
        q_bits  = {UNROLL{1'b0}};
        for (int i = 0; i < UNROLL; i++) begin
            trial_s = {rem_s, sh_s[XLEN-1]};
            sh_s    = {sh_s[XLEN-2:0], 1'b0};
            if (trial_s >= {1'b0, divisor}) begin
                trial_s               = trial_s - {1'b0, divisor};
                q_bits[UNROLL-1-i]    = 1'b1;
            end else begin
                q_bits[UNROLL-1-i]    = 1'b0;
            end
            rem_s = trial_s[XLEN-1:0];
        end
        rem_out = rem_s;
        sh_out  = sh_s;
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. Magnitudes are
// divided unsigned, UNROLL quotient bits per cycle, and signs are applied
// in a single fix-up cycle. Divide-by-zero and signed overflow bypass the
// iteration and respond one cycle after accept.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int XLEN   = DIV_XLEN,
    parameter int UNROLL = 1,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [TAGW-1:0] req_tag,
    input  logic            kill,
    output logic            busy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [TAGW-1:0] rsp_tag
);

    localparam int NITER = XLEN / UNROLL;
    localparam int CNTW  = (NITER > 1) ? $clog2(NITER) : 1;
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_r;
    logic [CNTW-1:0]   cnt_r;
    logic [1:0]        op_r;
    logic              sign_a_r;
    logic              sign_b_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   sh_r;
    logic [XLEN-1:0]   dvsr_r;

    logic [XLEN-1:0]   rem_next_s;
    logic [XLEN-1:0]   sh_next_s;
    logic [UNROLL-1:0] q_bits_s;

    logic              is_signed_s;
    logic              b_zero_s;
    logic              ovf_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic [XLEN-1:0]   fast_data_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_data_s;

    // Magnitude of an operand; only negated when the op is signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
        if (sgn && x[XLEN-1]) begin
            return ZERO - x;
        end else begin
            return x;
        end
    endfunction

    div_step #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_step (
        .rem_in  (rem_r),
        .sh_in   (sh_r),
        .divisor (dvsr_r),
        .rem_out (rem_next_s),
        .sh_out  (sh_next_s),
        .q_bits  (q_bits_s)
    );

    // Request decode: operand magnitudes and fast-path detection/result.
    always_comb begin
        is_signed_s = ~req_op[0];
        b_zero_s    = (req_b == ZERO);
        ovf_s       = is_signed_s && (req_a == MIN_VAL) && (req_b == ONES);
        abs_a_s     = abs_val(req_a, is_signed_s);
        abs_b_s     = abs_val(req_b, is_signed_s);
        if (b_zero_s) begin
            fast_data_s = req_op[1] ? req_a : ONES;
        end else if (ovf_s) begin
            fast_data_s = req_op[1] ? ZERO : MIN_VAL;
        end else begin
            fast_data_s = ZERO;
        end
    end

    // Sign fix-up of the unsigned quotient/remainder and result select.
    always_comb begin
        if ((op_r == DIV_OP_DIV) && (sign_a_r ^ sign_b_r)) begin
            quo_fix_s = ZERO - sh_r;
        end else begin
            quo_fix_s = sh_r;
        end
        if ((op_r == DIV_OP_REM) && sign_a_r) begin
            rem_fix_s = ZERO - rem_r;
        end else begin
            rem_fix_s = rem_r;
        end
        if (op_r[1]) begin
            fix_data_s = rem_fix_s;
        end else begin
            fix_data_s = quo_fix_s;
        end
    end

    // Control FSM with operand registers and registered handshake outputs;
    // kill only returns control to IDLE and leaves the datapath alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= ZERO;
            rsp_tag   <= {TAGW{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
            op_r      <= 2'b00;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            rem_r     <= ZERO;
            sh_r      <= ZERO;
            dvsr_r    <= ZERO;
        end else if (kill) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op;
                        rsp_tag   <= req_tag;
                        sign_a_r  <= is_signed_s & req_a[XLEN-1];
                        sign_b_r  <= is_signed_s & req_b[XLEN-1];
                        rem_r     <= ZERO;
                        sh_r      <= abs_a_s;
                        dvsr_r    <= abs_b_s;
                        cnt_r     <= CNTW'(NITER - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (b_zero_s || ovf_s) begin
                            rsp_data  <= fast_data_s;
                            rsp_valid <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            state_r   <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    rem_r <= rem_next_s;
                    sh_r  <= sh_next_s | {{(XLEN-UNROLL){1'b0}}, q_bits_s};
                    if (cnt_r == {CNTW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r   <= cnt_r - CNTW'(1);
                    end
                end
                ST_FIX: begin
                    rsp_data  <= fix_data_s;
                    rsp_valid <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: three configurations
// (32/1, 32/4, 64/2) sharing clock, reset, kill and request buses.
module tb_div_iter;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst, kill, rsp_ready;
    logic [1:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        rqv0, rqv1, rqv2;
    logic        rr0, rr1, rr2, busy0, busy1, busy2, rv0, rv1, rv2;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    logic [4:0]  rt0, rt1, rt2;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    div_iter #(.XLEN(32), .UNROLL(1), .TAGW(5)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rqv0), .req_ready(rr0), .req_op(req_op),
        .req_a(req_a[31:0]), .req_b(req_b[31:0]), .req_tag(req_tag), .kill(kill),
        .busy(busy0), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_tag(rt0));

    div_iter #(.XLEN(32), .UNROLL(4), .TAGW(5)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rqv1), .req_ready(rr1), .req_op(req_op),
        .req_a(req_a[31:0]), .req_b(req_b[31:0]), .req_tag(req_tag), .kill(kill),
        .busy(busy1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_tag(rt1));

    div_iter #(.XLEN(64), .UNROLL(2), .TAGW(5)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rqv2), .req_ready(rr2), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .kill(kill),
        .busy(busy2), .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_data(rd2), .rsp_tag(rt2));

    function automatic logic get_rv(input int d);
        case (d)
            0:       return rv0;
            1:       return rv1;
            default: return rv2;
        endcase
    endfunction

    function automatic logic get_rr(input int d);
        case (d)
            0:       return rr0;
            1:       return rr1;
            default: return rr2;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [63:0] get_data(input int d);
        case (d)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            default: return rd2;
        endcase
    endfunction

    function automatic logic [4:0] get_tag(input int d);
        case (d)
            0:       return rt0;
            1:       return rt1;
            default: return rt2;
        endcase
    endfunction

    function automatic int norm_lat(input int d);
        case (d)
            0:       return 34;
            1:       return 10;
            default: return 34;
        endcase
    endfunction

    task automatic set_valid(input int d, input logic v);
        case (d)
            0:       rqv0 = v;
            1:       rqv1 = v;
            default: rqv2 = v;
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model for RISC-V division semantics.
    task automatic ref_model(input int w, input logic [1:0] o, input logic [63:0] x,
                             input logic [63:0] y, output logic [63:0] r, output logic fast);
        logic [63:0] mask, xa, yb, minv;
        longint      sx, sy;
        logic        ovf;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        minv = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        xa   = x & mask;
        yb   = y & mask;
        if (w == 32) begin
            sx = {{32{x[31]}}, x[31:0]};
            sy = {{32{y[31]}}, y[31:0]};
        end else begin
            sx = x;
            sy = y;
        end
        ovf  = !o[0] && (xa == minv) && (yb == mask);
        fast = (yb == 64'h0) || ovf;
        if (yb == 64'h0) r = o[1] ? xa : mask;
        else if (ovf)    r = o[1] ? 64'h0 : minv;
        else begin
            case (o)
                OP_DIV:  r = 64'(sx / sy) & mask;
                OP_REM:  r = 64'(sx % sy) & mask;
                OP_DIVU: r = (xa / yb) & mask;
                default: r = (xa % yb) & mask;
            endcase
        end
    endtask

    // Issue one request, measure latency, hold the response for 'hold'
    // cycles, then complete the handshake.
    task automatic do_op(input int d, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [4:0] t, input logic [63:0] exp,
                         input int exp_lat, input int hold, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, " ready"}, 64'(get_rr(d)), 64'd1);
        req_op = o; req_a = x; req_b = y; req_tag = t;
        set_valid(d, 1'b1);
        @(posedge clk); #1;
        set_valid(d, 1'b0);
        lat = 1;
        while (get_rv(d) !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " data"}, get_data(d), exp);
        chk({nm, " tag"}, 64'(get_tag(d)), 64'(t));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"}, 64'(get_rv(d)), 64'd1);
            chk({nm, " hold data"}, get_data(d), exp);
            chk({nm, " hold tag"}, 64'(get_tag(d)), 64'(t));
            chk({nm, " hold ready"}, 64'(get_rr(d)), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, " post valid"}, 64'(get_rv(d)), 64'd0);
        chk({nm, " post ready"}, 64'(get_rr(d)), 64'd1);
        chk({nm, " post busy"}, 64'(get_busy(d)), 64'd0);
    endtask

    initial begin
        logic [63:0] x, y, e;
        logic        fast;
        logic [1:0]  o;
        int          w;
        logic        seen;

        rst = 1'b1; kill = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_a = 64'h0; req_b = 64'h0; req_tag = 5'd0;
        rqv0 = 1'b0; rqv1 = 1'b0; rqv2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", 64'(rr0), 64'd1);
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst valid", 64'(rv0), 64'd0);
        chk("rst data", 64'(rd0), 64'd0);
        chk("rst tag", 64'(rt0), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 32-bit, one bit per cycle
        do_op(0, OP_DIV,  64'd100,        64'hFFFF_FFF9, 5'd1, 64'hFFFF_FFF2, 34, 0, "div100_m7");
        do_op(0, OP_REM,  64'hFFFF_FF9C,  64'd7,         5'd2, 64'hFFFF_FFFE, 34, 0, "rem_m100_7");
        do_op(0, OP_REMU, 64'hFFFF_FFFF,  64'h10,        5'd3, 64'hF,         34, 0, "remu_ff_10");
        do_op(0, OP_DIVU, 64'hFFFF_FFFF,  64'd1,         5'd4, 64'hFFFF_FFFF, 34, 0, "divu_ff_1");
        do_op(0, OP_REM,  64'd100,        64'hFFFF_FFF9, 5'd5, 64'd2,         34, 0, "rem100_m7");
        do_op(0, OP_DIVU, 64'h8000_0000,  64'hFFFF_FFFF, 5'd6, 64'd0,         34, 0, "divu_min_ff");
        do_op(0, OP_DIV,  64'd5,          64'd0,         5'd7, 64'hFFFF_FFFF, 1,  0, "div5_0");
        do_op(0, OP_REM,  64'd5,          64'd0,         5'd8, 64'd5,         1,  0, "rem5_0");
        do_op(0, OP_DIV,  64'h8000_0000,  64'hFFFF_FFFF, 5'd9, 64'h8000_0000, 1,  0, "div_ovf");
        do_op(0, OP_REM,  64'h8000_0000,  64'hFFFF_FFFF, 5'd10, 64'd0,        1,  0, "rem_ovf");

        // Backpressure: five cycles with rsp_ready low in DONE
        do_op(0, OP_DIVU, 64'd100, 64'd7, 5'd11, 64'd14, 34, 5, "bp_divu");
        @(posedge clk); #1;
        chk("bp single rsp", 64'(rv0), 64'd0);

        // Response accepted in the same cycle DONE is entered
        @(negedge clk);
        rsp_ready = 1'b1;
        req_op = OP_DIV; req_a = 64'd5; req_b = 64'd0; req_tag = 5'd12; rqv0 = 1'b1;
        @(posedge clk); #1;
        rqv0 = 1'b0;
        chk("same valid", 64'(rv0), 64'd1);
        chk("same data", 64'(rd0), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("same post valid", 64'(rv0), 64'd0);
        chk("same post ready", 64'(rr0), 64'd1);

        // Kill at ITER cycle 10 with req_valid high
        @(negedge clk);
        req_op = OP_DIV; req_a = 64'd1000; req_b = 64'd3; req_tag = 5'd3; rqv0 = 1'b1;
        @(posedge clk); #1;
        rqv0 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("kill pre busy", 64'(busy0), 64'd1);
        kill = 1'b1; rqv0 = 1'b1; req_a = 64'd50; req_b = 64'd5; req_tag = 5'd20;
        @(posedge clk); #1;
        chk("kill busy", 64'(busy0), 64'd0);
        chk("kill valid", 64'(rv0), 64'd0);
        chk("kill ready", 64'(rr0), 64'd1);
        @(negedge clk);
        kill = 1'b0; rqv0 = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rv0 || busy0) seen = 1'b1;
        end
        chk("kill no rsp", 64'(seen), 64'd0);
        do_op(0, OP_DIV, 64'd9, 64'd3, 5'd7, 64'd3, 34, 0, "div9_3");

        // Reset in the middle of an operation
        @(negedge clk);
        req_op = OP_DIVU; req_a = 64'd77; req_b = 64'd5; req_tag = 5'd9; rqv0 = 1'b1;
        @(posedge clk); #1;
        rqv0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst ready", 64'(rr0), 64'd1);
        chk("mrst busy", 64'(busy0), 64'd0);
        chk("mrst valid", 64'(rv0), 64'd0);
        chk("mrst data", 64'(rd0), 64'd0);
        chk("mrst tag", 64'(rt0), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 32-bit, four bits per cycle
        do_op(1, OP_DIV,  64'hFFFF_FF9C, 64'd7,      5'd1, 64'hFFFF_FFF2, 10, 0, "u4_div");
        do_op(1, OP_REMU, 64'hDEAD_BEEF, 64'h100,    5'd2, 64'hEF,        10, 0, "u4_remu");
        do_op(1, OP_DIVU, 64'hDEAD_BEEF, 64'h1_0000, 5'd3, 64'hDEAD,      10, 0, "u4_divu");
        do_op(1, OP_DIV,  64'h8000_0000, 64'd2,      5'd4, 64'hC000_0000, 10, 0, "u4_divmin");

        // 64-bit, two bits per cycle
        do_op(2, OP_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd1,
              64'hFFFF_FFFF_FFFF_FFF2, 34, 0, "x64_div");
        do_op(2, OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd2,
              64'h5555_5555_5555_5555, 34, 0, "x64_divu");
        do_op(2, OP_REMU, 64'h1234_5678_9ABC_DEF0, 64'h1_0000_0000, 5'd3,
              64'h9ABC_DEF0, 34, 0, "x64_remu");
        do_op(2, OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
              64'd0, 1, 0, "x64_rem_ovf");

        // Mixed signed/unsigned operands against the reference model
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
                w = (d == 2) ? 64 : 32;
                x = {$urandom, $urandom};
                case (i % 3)
                    0:       y = {$urandom, $urandom};
                    1:       y = 64'($urandom_range(0, 50));
                    default: y = 64'h0 - 64'($urandom_range(1, 50));
                endcase
                if (w == 32) begin
                    x = x & 64'h0000_0000_FFFF_FFFF;
                    y = y & 64'h0000_0000_FFFF_FFFF;
                end
                o = 2'(i + d);
                ref_model(w, o, x, y, e, fast);
                do_op(d, o, x, y, 5'(i + 8 * d), e, fast ? 1 : norm_lat(d), 0, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
